instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 pcsel  input  1  SHALL select the redirect target (1) or sequential PC+4 (0) when the current instruction retires.
REQ-005 alu_target  input  32  SHALL be the branch or jump target computed by the ALU for the current instruction.
REQ-006 instr_ready  input  1  SHALL indicate that the downstream decode/control/execute path consumes the held instruction this cycle.
REQ-007 imem_req  output  1  SHALL request a 32-bit instruction read from instruction memory.
REQ-008 imem_addr  output  32  SHALL be the fetch address, valid while imem_req=1.
REQ-009 imem_ack  input  1  SHALL mark imem_rdata valid for the outstanding request.
REQ-010 imem_rdata  input  32  SHALL be the returned instruction word.
REQ-011 instr  output  32  SHALL be the held instruction presented to control logic.
REQ-012 instr_valid  output  1  SHALL mark instr, pc and pc_plus4 valid.
REQ-013 pc  output  32  SHALL be the address of the held instruction.
REQ-014 pc_plus4  output  32  SHALL equal pc+4 (modulo 2^32) for link writeback.
REQ-015 misalign  output  1  SHALL flag a misaligned redirect (present only when the macro in the Configuration section is defined).

Function
REQ-016 The FSM SHALL have states IDLE, FETCH and HOLD, plus TRAP when the macro is defined.
REQ-017 IDLE SHALL last exactly one cycle after reset release and then move to FETCH with imem_addr=RESET_PC.
REQ-018 In FETCH, imem_req SHALL be 1 and imem_addr SHALL stay stable until imem_ack=1.
REQ-019 On imem_ack in FETCH, the block SHALL capture imem_rdata into instr, move to HOLD, and assert instr_valid in the next cycle (1-cycle latency from ack).
REQ-020 In HOLD, imem_req SHALL be 0, and instr, pc and instr_valid SHALL remain stable until instr_ready=1.
REQ-021 On instr_ready in HOLD, the next PC SHALL be {alu_target[31:2],2'b00} if pcsel=1, else pc+4; the FSM SHALL move to FETCH and drop instr_valid in the same edge.
REQ-022 pcsel and alu_target SHALL be sampled only in HOLD with instr_ready=1 and ignored at all other times.
REQ-023 imem_ack outside FETCH SHALL be ignored.
REQ-024 PC arithmetic SHALL wrap: pc=32'hFFFF_FFFC sequential next SHALL be 32'h0000_0000.
REQ-025 A single-cycle-latency memory (ack in the first FETCH cycle) SHALL yield one instruction every 2 cycles at best; no extra bubbles.

Reset
REQ-026 While rst_n=0, outputs SHALL be: imem_req=0, imem_addr=RESET_PC, instr=32'h0000_0013 (NOP), instr_valid=0, pc=RESET_PC, pc_plus4=RESET_PC+4, misalign=0, state=IDLE.
REQ-027 Reset asserted mid-fetch SHALL deassert imem_req immediately (asynchronously), and any later ack for the aborted request SHALL be ignored.

Configuration
REQ-028 Macro FETCH_MISALIGN_TRAP_EN defined: a redirect with alu_target[1]=1 SHALL enter TRAP, set misalign=1 (sticky until reset), keep imem_req=0 and instr_valid=0.
REQ-029 Macro FETCH_MISALIGN_TRAP_EN undefined: the misalign port and the TRAP state SHALL be absent, and alu_target[1:0] SHALL be silently forced to 2'b00.

Verification
REQ-030 Reset release with RESET_PC=0 and ack after 1 cycle -> imem_addr=0 and imem_req=1 in cycle 2, instr_valid=1 with pc=0 one cycle after ack.
REQ-031 Sequential run with ack held at 1 and instr_ready held at 1 -> addresses 0,4,8,C on consecutive fetches, each instruction held exactly 1 cycle.
REQ-032 instr_ready=0 for 5 cycles in HOLD -> instr and pc unchanged and imem_req=0 throughout.
REQ-033 pcsel=1, alu_target=32'h0000_0101 on retire -> next imem_addr=32'h0000_0100, pc_plus4 of the prior instruction still pc+4.
REQ-034 pc=32'hFFFF_FFFC, pcsel=0, retire -> next imem_addr=32'h0000_0000.
REQ-035 With the macro defined, alu_target=32'h0000_0102 redirect -> misalign=1, no further imem_req until rst_n=0, then misalign=0.

Source files
------------

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch -- single-outstanding instruction fetch unit.
//
// Fetches one 32-bit instruction at a time and holds it for the
// decode/control/execute path. The FSM runs IDLE -> FETCH -> HOLD, then
// HOLD -> FETCH each time the held instruction retires. The next PC is
// either PC+4 or a word-aligned ALU redirect target.
//
// Optional feature (macro FETCH_MISALIGN_TRAP_EN):
//   defined   : a redirect with alu_target[1]=1 enters TRAP, raises the
//               sticky misalign flag and stops fetching until reset.
//   undefined : no misalign port and no TRAP state; alu_target[1:0] is
//               forced to 2'b00.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   pcsel, alu_target   redirect select and target, sampled on retire only
//   instr_ready         downstream consumes the held instruction
//   imem_req/imem_addr  instruction memory read request and address
//   imem_ack/imem_rdata memory response for the outstanding request
//   instr, instr_valid  held instruction and its valid flag
//   pc, pc_plus4        address of the held instruction and pc+4
//   misalign            sticky misaligned-redirect flag (macro only)
// ---------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pcsel,
    input  logic [31:0] alu_target,
    input  logic        instr_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        misalign
`endif
);

    localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_HOLD  = 2'b10,
        ST_TRAP  = 2'b11
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_HOLD  = 2'b10
    } state_t;
`endif

    state_t      state_r, state_nxt_s;
    logic        req_r, req_nxt_s;
    logic        valid_r, valid_nxt_s;
    logic [31:0] instr_r, instr_nxt_s;
    logic [31:0] pc_r, pc_nxt_s;
    logic [31:0] pc_plus4_r, pc_plus4_nxt_s;
    logic [31:0] target_s;
    logic        unused_tgt_bits_s;

    // Low target bits never reach the PC; bit 1 only feeds the trap check.
    assign unused_tgt_bits_s = ^alu_target[1:0];

    // Next fetch address on retire; redirect targets are always word aligned.
    assign target_s = pcsel ? {alu_target[31:2], 2'b00} : (pc_r + 32'd4);

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_r, misalign_nxt_s;
    logic trap_s;

    assign trap_s = pcsel & alu_target[1];
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                state_nxt_s = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (instr_ready) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (trap_s) begin
                        state_nxt_s = ST_TRAP;
                    end else begin
                        state_nxt_s = ST_FETCH;
                    end
`else
                    state_nxt_s = ST_FETCH;
`endif
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            ST_TRAP: begin
                state_nxt_s = ST_TRAP;
            end
`endif
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs, following the state transition.
    always_comb begin
        req_nxt_s      = req_r;
        valid_nxt_s    = valid_r;
        instr_nxt_s    = instr_r;
        pc_nxt_s       = pc_r;
        pc_plus4_nxt_s = pc_plus4_r;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_nxt_s = misalign_r;
`endif
        case (state_r)
            ST_IDLE: begin
                req_nxt_s = 1'b1;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_nxt_s = imem_rdata;
                    valid_nxt_s = 1'b1;
                    req_nxt_s   = 1'b0;
                end else begin
                    req_nxt_s   = 1'b1;
                end
            end
            ST_HOLD: begin
                if (instr_ready) begin
                    valid_nxt_s = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (trap_s) begin
                        misalign_nxt_s = 1'b1;
                        req_nxt_s      = 1'b0;
                    end else begin
                        req_nxt_s      = 1'b1;
                        pc_nxt_s       = target_s;
                        pc_plus4_nxt_s = target_s + 32'd4;
                    end
`else
                    req_nxt_s      = 1'b1;
                    pc_nxt_s       = target_s;
                    pc_plus4_nxt_s = target_s + 32'd4;
`endif
                end else begin
                    req_nxt_s = 1'b0;
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            ST_TRAP: begin
                req_nxt_s      = 1'b0;
                valid_nxt_s    = 1'b0;
                misalign_nxt_s = 1'b1;
            end
`endif
            default: begin
                req_nxt_s   = 1'b0;
                valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Output registers; reset drops imem_req asynchronously, aborting a fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_r      <= 1'b0;
            valid_r    <= 1'b0;
            instr_r    <= NOP;
            pc_r       <= RESET_PC;
            pc_plus4_r <= RESET_PC + 32'd4;
        end else begin
            req_r      <= req_nxt_s;
            valid_r    <= valid_nxt_s;
            instr_r    <= instr_nxt_s;
            pc_r       <= pc_nxt_s;
            pc_plus4_r <= pc_plus4_nxt_s;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    // Sticky misalign flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_r <= 1'b0;
        end else begin
            misalign_r <= misalign_nxt_s;
        end
    end

    assign misalign = misalign_r;
`endif

    // The fetch address register doubles as the held-instruction PC.
    assign imem_req    = req_r;
    assign imem_addr   = pc_r;
    assign instr       = instr_r;
    assign instr_valid = valid_r;
    assign pc          = pc_r;
    assign pc_plus4    = pc_plus4_r;

endmodule
